// File: rtl/blk_mem_arbiter_pkg.sv
// Shared types and constants for the block-memory arbiter.
//   state_e   : arbiter FSM states (IDLE, BUSY, DONE)
//   owner_e   : which cache side owns the current transfer
//   cnt_width : width of the watchdog counter for a given timeout
package blk_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int BLK_W_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // ceil(log2(timeout+1)), never narrower than one bit so a disabled
  // watchdog (timeout = 0) still has a legal counter width.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/blk_mem_arbiter_if.sv
// Bundle of the cache-side handshakes, the memory block port and the
// pipeline status outputs of the block-memory arbiter.
//   master : arbiter view (drives done/rdata, mem_*, FREEZE, err)
//   slave  : environment view (caches + memory + pipeline)
interface blk_mem_arbiter_if
  import blk_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BLK_W  = BLK_W_DEF
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [BLK_W-1:0]  i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [BLK_W-1:0]  d_wdata;
  logic              d_done;
  logic [BLK_W-1:0]  d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata;
  logic              mem_ready;
  logic [BLK_W-1:0]  mem_rdata;

  logic              FREEZE;
  logic              err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, FREEZE, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, FREEZE, err
  );

endinterface

// File: rtl/blk_mem_arbiter_watchdog.sv
// Saturating cycle counter that flags when a memory transfer has waited
// limit_i cycles.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : return the counter to zero
//   count_i   : advance the counter by one this cycle
//   limit_i   : timeout in cycles, 0 disables expiry
//   expired_o : counter has reached limit_i-1
module arb_watchdog #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             count_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
    end else if (count_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Expiry fires on the cycle the count sits at limit-1, so the owner has
  // spent exactly limit BUSY cycles waiting when the FSM gives up.
  assign expired_o = (limit_i != '0) && (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/blk_mem_arbiter.sv
// Arbitrates the single 256-bit main-memory block port between I-cache
// miss reads and D-cache miss reads/write-backs, one transfer at a time.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : blk_mem_arbiter_if.master (cache handshakes, memory port,
//                FREEZE pipeline stall, sticky watchdog err)
module blk_mem_arbiter
  import blk_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLK_W   = BLK_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  blk_mem_arbiter_if.master bus
);

  localparam int               CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_grant_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BLK_W-1:0]  mem_wdata_q;
  logic              i_done_q;
  logic              d_done_q;
  logic [BLK_W-1:0]  i_rdata_q;
  logic [BLK_W-1:0]  d_rdata_q;
  logic              err_q;

  owner_e            grant_d;
  logic              grant_vld;
  logic              wd_expired;

  // Round-robin pick: on contention the side that did not win last time
  // gets the port, so each requester waits at most one transfer.
  always_comb begin
    grant_d   = OWN_I;
    grant_vld = 1'b0;
    if (bus.i_req && bus.d_req) begin
      grant_vld = 1'b1;
      grant_d   = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
    end else if (bus.d_req) begin
      grant_vld = 1'b1;
      grant_d   = OWN_D;
    end else if (bus.i_req) begin
      grant_vld = 1'b1;
      grant_d   = OWN_I;
    end
  end

  arb_watchdog #(.CNT_W(CNT_W)) u_watchdog (
    .clk       (CLK),
    .rst       (RESET),
    .clear_i   (state_q == DONE),
    .count_i   ((state_q == BUSY) && !bus.mem_ready),
    .limit_i   (LIMIT),
    .expired_o (wd_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            mem_req_q    <= 1'b1;
            if (grant_d == OWN_D) begin
              mem_addr_q  <= bus.d_addr;
              mem_we_q    <= bus.d_we;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              mem_addr_q  <= bus.i_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // mem_ready wins over an expiry landing on the same cycle.
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            if (owner_q == OWN_D) begin
              d_rdata_q <= bus.mem_rdata;
              d_done_q  <= 1'b1;
            end else begin
              i_rdata_q <= bus.mem_rdata;
              i_done_q  <= 1'b1;
            end
            state_q <= DONE;
          end else if (wd_expired) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (owner_q == OWN_D) begin
              d_rdata_q <= '0;
              d_done_q  <= 1'b1;
            end else begin
              i_rdata_q <= '0;
              i_done_q  <= 1'b1;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;

  // Combinational so the pipeline stalls in the very cycle a miss is raised.
  assign bus.FREEZE = bus.i_req | bus.d_req | (state_q != IDLE);

endmodule

// File: tb/tb_blk_mem_arbiter.sv
`timescale 1ns/1ps
module tb_blk_mem_arbiter;

  localparam int AW = 32;
  localparam int BW = 256;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  blk_mem_arbiter_if #(.ADDR_W(AW), .BLK_W(BW)) bus ();

  blk_mem_arbiter #(.ADDR_W(AW), .BLK_W(BW), .TIMEOUT(TO)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    int            lat;
    logic [BW-1:0] mdata;
    logic [BW-1:0] exp_rdata;
    int            exp_cyc;
    bit            exp_err;
  } vec_t;

  vec_t vecs [8];

  int checks   = 0;
  int failures = 0;

  // Memory model knobs
  int            mem_lat       = 0;
  bit            mem_tied      = 1'b0;
  bit            mem_addr_mode = 1'b0;
  logic [BW-1:0] mem_data      = '0;
  int            busy_cnt      = 0;

  logic [BW-1:0] exp_i_q [$];
  logic [BW-1:0] exp_d_q [$];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] resp_data();
    return mem_addr_mode ? {8{bus.mem_addr}} : mem_data;
  endfunction

  // Memory responder: ready in the mem_lat-th cycle of mem_req (never if 0),
  // or permanently high in tied mode. Non-ready cycles carry junk data.
  always @(posedge CLK) begin
    #1;
    if (mem_tied) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = resp_data();
    end else if (bus.mem_req && !bus.mem_ready) begin
      busy_cnt++;
      if (busy_cnt == mem_lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = resp_data();
      end else begin
        bus.mem_rdata = ~resp_data();
      end
    end else begin
      bus.mem_ready = 1'b0;
      busy_cnt      = 0;
      bus.mem_rdata = ~resp_data();
    end
  end

  // Scoreboard: every done pulse must match the oldest expected block.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.i_done) begin
        if (exp_i_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL i_done_unexpected actual=1 required=0");
        end else begin
          check("sb_i_rdata", bus.i_rdata, exp_i_q.pop_front());
        end
      end
      if (bus.d_done) begin
        if (exp_d_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL d_done_unexpected actual=1 required=0");
        end else begin
          check("sb_d_rdata", bus.d_rdata, exp_d_q.pop_front());
        end
      end
    end
  end

  task automatic run_xfer(input vec_t v, input string tag);
    logic [BW-1:0] other_before;
    int  seen;
    bit  freeze_ok;
    mem_lat       = v.lat;
    mem_data      = v.mdata;
    mem_addr_mode = 1'b0;
    other_before  = v.is_d ? bus.i_rdata : bus.d_rdata;
    @(posedge CLK); #1;
    bus.d_wdata = v.wdata;
    bus.d_we    = v.we;
    if (v.is_d) begin
      bus.d_req  = 1'b1;
      bus.d_addr = v.addr;
      exp_d_q.push_back(v.exp_rdata);
    end else begin
      bus.i_req  = 1'b1;
      bus.i_addr = v.addr;
      exp_i_q.push_back(v.exp_rdata);
    end
    @(negedge CLK);
    check({tag, "_freeze_c0"}, BW'(bus.FREEZE), BW'(1'b1));
    seen      = 0;
    freeze_ok = 1'b1;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!bus.FREEZE) freeze_ok = 1'b0;
      if (c == 1) begin
        check({tag, "_mem_req_c1"}, BW'(bus.mem_req), BW'(1'b1));
        check({tag, "_mem_addr"}, BW'(bus.mem_addr), BW'(v.addr));
        check({tag, "_mem_we"}, BW'(bus.mem_we), BW'(v.is_d & v.we));
        check({tag, "_mem_wdata"}, bus.mem_wdata, v.is_d ? v.wdata : '0);
      end else if (c == v.exp_cyc - 1) begin
        check({tag, "_mem_req_last_busy"}, BW'(bus.mem_req), BW'(1'b1));
      end
      if ((v.is_d && bus.d_done) || (!v.is_d && bus.i_done)) begin
        seen = c;
        check({tag, "_mem_req_done"}, BW'(bus.mem_req), BW'(1'b0));
      end
    end
    check({tag, "_done_cycle"}, BW'(seen), BW'(v.exp_cyc));
    check({tag, "_freeze"}, BW'(freeze_ok), BW'(1'b1));
    check({tag, "_err"}, BW'(bus.err), BW'(v.exp_err));
    check({tag, "_other_rdata"}, v.is_d ? bus.i_rdata : bus.d_rdata, other_before);
    @(posedge CLK); #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  task automatic contention(input bit first_is_d, input logic [AW-1:0] ia,
                            input logic [AW-1:0] da, input string tag);
    int i_cyc;
    int d_cyc;
    mem_lat       = 2;
    mem_addr_mode = 1'b1;
    @(posedge CLK); #1;
    bus.i_req  = 1'b1;
    bus.i_addr = ia;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = da;
    exp_i_q.push_back({8{ia}});
    exp_d_q.push_back({8{da}});
    i_cyc = 0;
    d_cyc = 0;
    for (int c = 1; c <= 40 && (i_cyc == 0 || d_cyc == 0); c++) begin
      @(posedge CLK); #1;
      if (i_cyc != 0) bus.i_req = 1'b0;
      if (d_cyc != 0) bus.d_req = 1'b0;
      @(negedge CLK);
      if (c == 1) check({tag, "_first_addr"}, BW'(bus.mem_addr), BW'(first_is_d ? da : ia));
      if (bus.i_done && i_cyc == 0) i_cyc = c;
      if (bus.d_done && d_cyc == 0) d_cyc = c;
    end
    check({tag, "_first_done_cycle"}, BW'(first_is_d ? d_cyc : i_cyc), BW'(3));
    check({tag, "_second_done_cycle"}, BW'(first_is_d ? i_cyc : d_cyc), BW'(7));
    @(posedge CLK); #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] b2b_addr [3];
    int b2b_cyc [3];
    int k;
    bit advance;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0400, {8{32'hCAFE_F00D}}, 3, {8{32'hA5A5_A5A5}}, {8{32'hA5A5_A5A5}}, 4, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_1000, {16{16'h1234}}, 2, {8{32'hDEAD_BEEF}}, {8{32'hDEAD_BEEF}}, 3, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_2040, {8{32'h0F0F_0F0F}}, 1, {4{64'h0123_4567_89AB_CDEF}}, {4{64'h0123_4567_89AB_CDEF}}, 2, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0080, {8{32'h1111_1111}}, 5, {8{32'h5A5A_5A5A}}, {8{32'h5A5A_5A5A}}, 6, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0500, {8{32'h2222_2222}}, 0, {8{32'hFFFF_FFFF}}, '0, TO + 1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0600, {8{32'h4444_4444}}, 2, {8{32'h33CC_33CC}}, {8{32'h33CC_33CC}}, 3, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0740, '0, 2, {8{32'h7777_8888}}, {8{32'h7777_8888}}, 3, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_07C0, '0, 1, {8{32'h600D_F00D}}, {8{32'h600D_F00D}}, 2, 1'b0};

    RESET       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_mem_req", BW'(bus.mem_req), '0);
    check("rst_mem_we", BW'(bus.mem_we), '0);
    check("rst_mem_addr", BW'(bus.mem_addr), '0);
    check("rst_mem_wdata", bus.mem_wdata, '0);
    check("rst_i_done", BW'(bus.i_done), '0);
    check("rst_d_done", BW'(bus.d_done), '0);
    check("rst_i_rdata", bus.i_rdata, '0);
    check("rst_d_rdata", bus.d_rdata, '0);
    check("rst_err", BW'(bus.err), '0);
    check("rst_freeze", BW'(bus.FREEZE), '0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // First contention after reset: D wins, I follows right after.
    contention(1'b1, 32'h0000_0A00, 32'h0000_0B00, "cont_a");

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // Last winner was D, so I now takes the port first.
    contention(1'b0, 32'h0000_0C00, 32'h0000_0D00, "cont_b");
    check("cont_b_err_sticky", BW'(bus.err), BW'(1'b1));

    // Reset while BUSY abandons the transfer and clears err.
    mem_lat       = 0;
    mem_addr_mode = 1'b0;
    @(posedge CLK); #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0700;
    repeat (3) @(posedge CLK);
    #1;
    check("rstmid_mem_req_before", BW'(bus.mem_req), BW'(1'b1));
    RESET     = 1'b1;
    bus.i_req = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("rstmid_mem_req", BW'(bus.mem_req), '0);
    check("rstmid_i_done", BW'(bus.i_done), '0);
    check("rstmid_err", BW'(bus.err), '0);
    check("rstmid_freeze", BW'(bus.FREEZE), '0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("rstmid_no_done", BW'(bus.i_done | bus.d_done), '0);
    end
    run_xfer(vecs[6], "after_rst");

    // Zero-wait memory: ready permanently high.
    mem_tied = 1'b1;
    run_xfer(vecs[7], "zero_wait");

    b2b_addr[0] = 32'h0000_3000;
    b2b_addr[1] = 32'h0000_3040;
    b2b_addr[2] = 32'h0000_3080;
    mem_addr_mode = 1'b1;
    @(posedge CLK); #1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = b2b_addr[0];
    for (int j = 0; j < 3; j++) begin
      exp_d_q.push_back({8{b2b_addr[j]}});
      b2b_cyc[j] = 0;
    end
    k       = 0;
    advance = 1'b0;
    for (int c = 1; c <= 40 && k < 3; c++) begin
      @(posedge CLK); #1;
      if (advance) begin
        bus.d_addr = b2b_addr[k];
        advance    = 1'b0;
      end
      @(negedge CLK);
      if (bus.d_done) begin
        b2b_cyc[k] = c;
        k++;
        advance = (k < 3);
      end
    end
    @(posedge CLK); #1;
    bus.d_req = 1'b0;
    check("b2b_done0", BW'(b2b_cyc[0]), BW'(2));
    check("b2b_done1", BW'(b2b_cyc[1]), BW'(5));
    check("b2b_done2", BW'(b2b_cyc[2]), BW'(8));
    mem_tied = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("end_freeze", BW'(bus.FREEZE), '0);
    check("sb_i_empty", BW'(exp_i_q.size()), '0);
    check("sb_d_empty", BW'(exp_d_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
